// File: rtl/datapath_sequencer_pkg.sv
// Shared definitions for the datapath control-step sequencer: state encoding,
// bus source codes, IR field positions and ALU function codes.
package datapath_sequencer_pkg;

  localparam int BUS_SEL_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5
  } state_e;

  localparam logic [4:0] SEL_R0   = 5'd0;
  localparam logic [4:0] SEL_HI   = 5'd16;
  localparam logic [4:0] SEL_LO   = 5'd17;
  localparam logic [4:0] SEL_ZHI  = 5'd18;
  localparam logic [4:0] SEL_ZLO  = 5'd19;
  localparam logic [4:0] SEL_PC   = 5'd20;
  localparam logic [4:0] SEL_IR   = 5'd21;
  localparam logic [4:0] SEL_MDR  = 5'd22;
  localparam logic [4:0] SEL_NONE = 5'd31;

  localparam int OPC_LSB = 27;
  localparam int RA_LSB  = 23;
  localparam int RB_LSB  = 19;
  localparam int RC_LSB  = 15;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_AND  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_SHR  = 5'd4,
    ALU_SHRA = 5'd5,
    ALU_SHL  = 5'd6,
    ALU_ROR  = 5'd7,
    ALU_ROL  = 5'd8,
    ALU_NEG  = 5'd9,
    ALU_NOT  = 5'd10,
    ALU_MUL  = 5'd11
  } alu_op_e;

  localparam logic [4:0] LAST_ALU_OP = ALU_MUL;

  function automatic logic [4:0] ir_opcode(input logic [31:0] ir);
    return ir[OPC_LSB +: 5];
  endfunction

  function automatic logic [3:0] ir_ra(input logic [31:0] ir);
    return ir[RA_LSB +: 4];
  endfunction

  function automatic logic [3:0] ir_rb(input logic [31:0] ir);
    return ir[RB_LSB +: 4];
  endfunction

  function automatic logic [3:0] ir_rc(input logic [31:0] ir);
    return ir[RC_LSB +: 4];
  endfunction

endpackage

// File: rtl/datapath_sequencer_if.sv
// Control/handshake bundle between the sequencer and the surrounding datapath.
interface datapath_sequencer_if
  import datapath_sequencer_pkg::*;
#(
  parameter int SEL_W = BUS_SEL_W
);
  logic             start;
  logic [31:0]      ir_q;
  logic             mem_ready;
  logic [SEL_W-1:0] bus_sel;
  logic             mar_load;
  logic             pc_load;
  logic             inc_pc;
  logic             mdr_load;
  logic             mem_read;
  logic             ir_load;
  logic             y_load;
  logic             z_load;
  logic             reg_load;
  logic [3:0]       reg_addr_in;
  logic [3:0]       alu_op;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, ir_q, mem_ready,
    input  bus_sel, mar_load, pc_load, inc_pc, mdr_load, mem_read, ir_load,
           y_load, z_load, reg_load, reg_addr_in, alu_op, busy, done, err
  );

  modport slave (
    input  start, ir_q, mem_ready,
    output bus_sel, mar_load, pc_load, inc_pc, mdr_load, mem_read, ir_load,
           y_load, z_load, reg_load, reg_addr_in, alu_op, busy, done, err
  );
endinterface

// File: rtl/datapath_sequencer_wait_counter.sv
// Memory-wait counter for the fetch step: counts stalled cycles and flags the
// last allowed one so the sequencer can abort on that same cycle.
module sequencer_wait_counter #(
  parameter int MAX = 15,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic term
);

  logic [W-1:0] count_q, count_d;

  // NOTE: every variable gets its default before the branches, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && count_q != W'(MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Terminal on the cycle whose stall would make the count reach MAX.
  assign term = (count_q == W'(MAX - 1));

endmodule

// File: rtl/datapath_sequencer.sv
// Control-step sequencer: fetches one instruction and runs a 3-register ALU
// op through steps T0..T5 on the shared datapath bus.
module datapath_sequencer
  import datapath_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int SEL_W       = BUS_SEL_W
) (
  input  logic                 clk,
  input  logic                 reset,
  datapath_sequencer_if.slave  dp
);

  state_e     state_q, state_d;
  logic       wait_en;
  logic       wait_term;
  logic [4:0] opcode;
  logic       unused_ir_bits;

  assign opcode         = ir_opcode(dp.ir_q);
  assign unused_ir_bits = ^dp.ir_q[RC_LSB-1:0];
  assign dp.busy        = (state_q != ST_IDLE);

  sequencer_wait_counter #(
    .MAX (MEM_TIMEOUT)
  ) u_wait_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q != ST_T1),
    .en    (wait_en),
    .term  (wait_term)
  );

  always_comb begin
    state_d        = state_q;
    wait_en        = 1'b0;
    dp.bus_sel     = SEL_W'(SEL_NONE);
    dp.mar_load    = 1'b0;
    dp.pc_load     = 1'b0;
    dp.inc_pc      = 1'b0;
    dp.mdr_load    = 1'b0;
    dp.mem_read    = 1'b0;
    dp.ir_load     = 1'b0;
    dp.y_load      = 1'b0;
    dp.z_load      = 1'b0;
    dp.reg_load    = 1'b0;
    dp.reg_addr_in = 4'd0;
    dp.alu_op      = 4'd0;
    dp.done        = 1'b0;
    dp.err         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (dp.start) state_d = ST_T0;
      end
      ST_T0: begin
        dp.bus_sel  = SEL_W'(SEL_PC);
        dp.mar_load = 1'b1;
        dp.inc_pc   = 1'b1;
        dp.z_load   = 1'b1;
        state_d     = ST_T1;
      end
      ST_T1: begin
        dp.mem_read = 1'b1;
        if (dp.mem_ready) begin
          dp.mdr_load = 1'b1;
          state_d     = ST_T2;
        end else begin
          wait_en = 1'b1;
          if (wait_term) begin
            dp.err  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_T2: begin
        dp.bus_sel = SEL_W'(SEL_MDR);
        dp.ir_load = 1'b1;
        state_d    = ST_T3;
      end
      ST_T3: begin
        // IR was loaded at the end of T2, so ir_q now holds the new instruction.
        if (opcode <= LAST_ALU_OP) begin
          dp.bus_sel = SEL_W'(ir_rb(dp.ir_q));
          dp.y_load  = 1'b1;
          state_d    = ST_T4;
        end else begin
          dp.err  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_T4: begin
        dp.bus_sel = SEL_W'(ir_rc(dp.ir_q));
        dp.alu_op  = opcode[3:0];
        dp.z_load  = 1'b1;
        state_d    = ST_T5;
      end
      ST_T5: begin
        dp.bus_sel     = SEL_W'(SEL_ZLO);
        dp.reg_load    = 1'b1;
        dp.reg_addr_in = ir_ra(dp.ir_q);
        dp.done        = 1'b1;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer: per-cycle comparison of every output
// against hand-written expected vectors.
module tb_datapath_sequencer;

  typedef struct packed {
    logic [4:0] sel;
    logic [7:0] stb;   // mar, pc, inc, mdr, mem_read, ir, y, z
    logic       reg_load;
    logic [3:0] ra;
    logic [3:0] alu;
    logic       busy;
    logic       done;
    logic       err;
  } obs_t;

  localparam logic [7:0] S_MAR = 8'h80;
  localparam logic [7:0] S_INC = 8'h20;
  localparam logic [7:0] S_MDR = 8'h10;
  localparam logic [7:0] S_MRD = 8'h08;
  localparam logic [7:0] S_IR  = 8'h04;
  localparam logic [7:0] S_Y   = 8'h02;
  localparam logic [7:0] S_Z   = 8'h01;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  datapath_sequencer_if dp ();

  datapath_sequencer u_dut (
    .clk   (clk),
    .reset (reset),
    .dp    (dp)
  );

  function automatic obs_t mk(input logic [4:0] sel, input logic [7:0] stb,
                              input logic rl, input logic [3:0] ra,
                              input logic [3:0] alu, input logic busy,
                              input logic done, input logic err);
    mk = {sel, stb, rl, ra, alu, busy, done, err};
  endfunction

  function automatic obs_t sample();
    sample = {dp.bus_sel, dp.mar_load, dp.pc_load, dp.inc_pc, dp.mdr_load,
              dp.mem_read, dp.ir_load, dp.y_load, dp.z_load, dp.reg_load,
              dp.reg_addr_in, dp.alu_op, dp.busy, dp.done, dp.err};
  endfunction

  function automatic logic [31:0] mkir(input logic [4:0] op, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic [3:0] rc);
    mkir = {op, ra, rb, rc, 15'd0};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected output vectors for the fixed steps.
  obs_t e_idle, e_t0, e_t1_rdy, e_t1_wait, e_t1_tmo, e_t2, e_t3_ill;

  initial begin
    e_idle    = mk(5'd31, 8'h00, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    e_t0      = mk(5'd20, S_MAR | S_INC | S_Z, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    e_t1_rdy  = mk(5'd31, S_MRD | S_MDR, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    e_t1_wait = mk(5'd31, S_MRD, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    e_t1_tmo  = mk(5'd31, S_MRD, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1);
    e_t2      = mk(5'd22, S_IR, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    e_t3_ill  = mk(5'd31, 8'h00, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1);
  end

  // One clock cycle: drive inputs just after the edge, then compare outputs.
  task automatic cyc(input logic st, input logic mr, input obs_t exp, input string tag);
    @(posedge clk);
    #1;
    dp.start     = st;
    dp.mem_ready = mr;
    #1;
    check(tag, 32'(sample()), 32'(exp));
  endtask

  task automatic issue(input string tag);
    cyc(1'b1, 1'b0, e_idle, tag);
  endtask

  // Steps T0 onwards; start is held at hs from T2 through the closing IDLE cycle.
  task automatic body(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb,
                      input logic [3:0] rc, input int waits, input logic hs);
    cyc(1'b0, 1'b0, e_t0, "t0");
    for (int i = 0; i < waits && i < 15; i++) begin
      cyc(1'b0, 1'b0, (i == 14) ? e_t1_tmo : e_t1_wait, "t1_wait");
    end
    if (waits >= 15) begin
      cyc(1'b0, 1'b0, e_idle, "timeout_idle");
      return;
    end
    cyc(1'b0, 1'b1, e_t1_rdy, "t1_ready");
    cyc(hs, 1'b0, e_t2, "t2");
    if (op > 5'd11) begin
      cyc(hs, 1'b0, e_t3_ill, "t3_illegal");
      cyc(hs, 1'b0, e_idle, "illegal_idle");
      return;
    end
    cyc(hs, 1'b0, mk({1'b0, rb}, S_Y, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0), "t3");
    cyc(hs, 1'b0, mk({1'b0, rc}, S_Z, 1'b0, 4'd0, op[3:0], 1'b1, 1'b0, 1'b0), "t4");
    cyc(hs, 1'b0, mk(5'd19, 8'h00, 1'b1, ra, 4'd0, 1'b1, 1'b1, 1'b0), "t5");
    cyc(hs, 1'b0, e_idle, "end_idle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b0;
    dp.start     = 1'b0;
    dp.mem_ready = 1'b0;
    dp.ir_q      = 32'd0;

    // Reset held low two cycles, with start raised to show reset wins.
    @(posedge clk);
    #1 dp.start = 1'b1;
    #1 check("rst_cycle1", 32'(sample()), 32'(e_idle));
    @(posedge clk);
    #1 reset = 1'b1;
    dp.start = 1'b0;
    #1 check("rst_release", 32'(sample()), 32'(e_idle));

    // Baseline: opcode 0 (add), ra=3 rb=1 rc=2, memory ready immediately.
    dp.ir_q = mkir(5'd0, 4'd3, 4'd1, 4'd2);
    issue("base_issue");
    body(5'd0, 4'd3, 4'd1, 4'd2, 0, 1'b0);

    // Memory stalls 3 cycles: T1 lasts 4 cycles.
    dp.ir_q = mkir(5'd1, 4'd5, 4'd6, 4'd7);
    issue("wait_issue");
    body(5'd1, 4'd5, 4'd6, 4'd7, 3, 1'b0);

    // Memory never ready: err on the 15th T1 cycle, then idle.
    dp.ir_q = mkir(5'd2, 4'd8, 4'd9, 4'd10);
    issue("tmo_issue");
    body(5'd2, 4'd8, 4'd9, 4'd10, 15, 1'b0);

    // Illegal opcodes 12 and 31, each followed by a normal instruction.
    dp.ir_q = mkir(5'd12, 4'd1, 4'd2, 4'd3);
    issue("ill12_issue");
    body(5'd12, 4'd1, 4'd2, 4'd3, 0, 1'b0);
    dp.ir_q = mkir(5'd11, 4'd15, 4'd0, 4'd14);
    issue("mul_issue");
    body(5'd11, 4'd15, 4'd0, 4'd14, 0, 1'b0);
    dp.ir_q = mkir(5'd31, 4'd2, 4'd2, 4'd2);
    issue("ill31_issue");
    body(5'd31, 4'd2, 4'd2, 4'd2, 0, 1'b0);

    // Start held high from T2: ignored while busy, restarts only from IDLE.
    dp.ir_q = mkir(5'd9, 4'd4, 4'd4, 4'd4);
    issue("b2b_issue");
    body(5'd9, 4'd4, 4'd4, 4'd4, 0, 1'b1);
    body(5'd9, 4'd4, 4'd4, 4'd4, 0, 1'b0);

    // Reset during T4: idle next edge, no reg_load and no done.
    dp.ir_q = mkir(5'd3, 4'd6, 4'd7, 4'd8);
    issue("rst4_issue");
    cyc(1'b0, 1'b0, e_t0, "rst4_t0");
    cyc(1'b0, 1'b1, e_t1_rdy, "rst4_t1");
    cyc(1'b0, 1'b0, e_t2, "rst4_t2");
    cyc(1'b0, 1'b0, mk(5'd7, S_Y, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0), "rst4_t3");
    @(posedge clk);
    #1 reset = 1'b0;
    #1 check("rst4_t4", 32'(sample()), 32'(mk(5'd8, S_Z, 1'b0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0)));
    cyc(1'b0, 1'b0, e_idle, "rst4_idle");
    @(posedge clk);
    #1 reset = 1'b1;
    #1 check("rst4_release", 32'(sample()), 32'(e_idle));
    dp.ir_q = mkir(5'd6, 4'd12, 4'd13, 4'd11);
    issue("recover_issue");
    body(5'd6, 4'd12, 4'd13, 4'd11, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
